// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 key schedule controller.
package aes_pkg;

  localparam int unsigned AES_ROUNDS = 10;
  localparam logic [7:0]  RCON_INIT  = 8'h01;
  localparam logic [7:0]  RCON_POLY  = 8'h1b;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef logic [3:0] rk_idx_t;

  // GF(2^8) doubling used to step the round constant
  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_sched_ctrl_if.sv
// Seed-key handshake bundle between key source and key schedule controller.
interface aes_key_sched_ctrl_if;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;

  modport master (output key_in, output key_valid, input  key_ready);
  modport slave  (input  key_in, input  key_valid, output key_ready);
endinterface

// File: rtl/aes_sbox.sv
// AES forward S-box: 8-bit combinational lookup.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key expansion controller: one round key per cycle into a register store,
// with registered indexed read-out and synchronous zeroise.
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned ROUNDS = AES_ROUNDS,
  parameter int unsigned IDX_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  aes_key_sched_ctrl_if.slave  key_if,
  input  logic                 key_clear,
  input  logic [IDX_W-1:0]     rk_idx,
  output logic [127:0]         rk_out,
  output logic                 busy,
  output logic                 keys_valid
);

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   round;
  logic [IDX_W-1:0]   round_m1;
  logic [7:0]         rcon;
  logic [127:0]       rk [ROUNDS+1];

  logic               ready_int;
  logic               handshake;
  logic               last_round;
  logic [127:0]       prev_key;
  logic [127:0]       next_key;
  logic [127:0]       rd_data;
  logic [31:0]        rot_w, sub_w, t_w;
  logic [31:0]        w0n, w1n, w2n, w3n;

  assign ready_int        = (state != ST_EXPAND);
  assign key_if.key_ready = ready_int;
  assign busy             = (state == ST_EXPAND);
  assign handshake        = key_if.key_valid && ready_int && !key_clear;
  assign last_round       = (state == ST_EXPAND) && (round == IDX_W'(ROUNDS));
  assign round_m1         = round - 1'b1;

  // Store mux: previous round key for expansion, indexed entry for read-out
  always_comb begin
    prev_key = '0;
    rd_data  = '0;
    for (int unsigned i = 0; i <= ROUNDS; i++) begin
      if (round_m1 == IDX_W'(i)) prev_key = rk[i];
      if (rk_idx   == IDX_W'(i)) rd_data  = rk[i];
    end
  end

  assign rot_w = {prev_key[23:0], prev_key[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .in_byte  (rot_w[8*b +: 8]),
      .out_byte (sub_w[8*b +: 8])
    );
  end

  assign t_w      = sub_w ^ {rcon, 24'h0};
  assign w0n      = prev_key[127:96] ^ t_w;
  assign w1n      = prev_key[95:64]  ^ w0n;
  assign w2n      = prev_key[63:32]  ^ w1n;
  assign w3n      = prev_key[31:0]   ^ w2n;
  assign next_key = {w0n, w1n, w2n, w3n};

  always_comb begin
    state_nxt = state;
    if (key_clear) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:   if (handshake)  state_nxt = ST_EXPAND;
        ST_EXPAND: if (last_round) state_nxt = ST_DONE;
        ST_DONE:   if (handshake)  state_nxt = ST_EXPAND;
        default:                   state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      round      <= '0;
      rcon       <= RCON_INIT;
      keys_valid <= 1'b0;
      rk_out     <= '0;
      for (int unsigned i = 0; i <= ROUNDS; i++) rk[i] <= '0;
    end else begin
      rk_out <= key_clear ? '0 : rd_data;
      if (key_clear) begin
        round      <= '0;
        rcon       <= RCON_INIT;
        keys_valid <= 1'b0;
        for (int unsigned i = 0; i <= ROUNDS; i++) rk[i] <= '0;
      end else if (handshake) begin
        rk[0]      <= key_if.key_in;
        round      <= IDX_W'(1);
        rcon       <= RCON_INIT;
        keys_valid <= 1'b0;
      end else if (state == ST_EXPAND) begin
        for (int unsigned i = 1; i <= ROUNDS; i++)
          if (round == IDX_W'(i)) rk[i] <= next_key;
        round <= round + 1'b1;
        rcon  <= xtime(rcon);
        if (last_round) keys_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed/randomised bench for aes_key_sched_ctrl against a FIPS-197 key expansion model.
module tb_aes_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_clear;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;
  logic         busy;
  logic         keys_valid;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sb [256];
  logic [127:0] exp_rk [16];

  aes_key_sched_ctrl_if kif ();

  aes_key_sched_ctrl #(.ROUNDS(10), .IDX_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_if     (kif),
    .key_clear  (key_clear),
    .rk_idx     (rk_idx),
    .rk_out     (rk_out),
    .busy       (busy),
    .keys_valid (keys_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse then affine transform
  function automatic void build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (gf_mul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
      sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endfunction

  function automatic void model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
        rc  = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 16; r++)
      exp_rk[r] = (r <= 10) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endfunction

  function automatic void model_clear();
    for (int r = 0; r < 16; r++) exp_rk[r] = 128'h0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic handshake(input logic [127:0] key);
    kif.key_in    = key;
    kif.key_valid = 1'b1;
    step();
    kif.key_valid = 1'b0;
  endtask

  // Edges from handshake until keys_valid, bounded
  task automatic wait_kv(input string tag);
    int n = 0;
    while (!keys_valid && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, 128'(n), 128'd10);
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < 16; i++) begin
      rk_idx = 4'(i);
      step();
      chk($sformatf("%s_rk%0d", tag, i), rk_out, exp_rk[i]);
    end
  endtask

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  initial begin
    logic [127:0] key_a, key_b, old_rk10;
    build_sbox();
    rst_n = 1'b0; key_clear = 1'b0; rk_idx = '0;
    kif.key_in = '0; kif.key_valid = 1'b0;
    model_clear();
    #1;
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_kv",   128'(keys_valid), 128'd0);
    chk("rst_rkout", rk_out, 128'h0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("idle_ready", 128'(kif.key_ready), 128'd1);
    chk("idle_busy",  128'(busy), 128'd0);

    // FIPS-197 vector
    handshake(FIPS_KEY);
    chk("fips_busy",  128'(busy), 128'd1);
    chk("fips_ready", 128'(kif.key_ready), 128'd0);
    wait_kv("fips");
    chk("fips_done_busy", 128'(busy), 128'd0);
    model_expand(FIPS_KEY);
    chk("fips_model_rk1",  exp_rk[1],  FIPS_RK1);
    chk("fips_model_rk10", exp_rk[10], FIPS_RK10);
    read_all("fips");
    rk_idx = 4'd0; step();
    rk_idx = 4'd10; #1;
    chk("lat_hold", rk_out, FIPS_KEY);
    step();
    chk("lat_rk10", rk_out, FIPS_RK10);

    // All-zero key restarted from DONE
    handshake(128'h0);
    chk("zero_kv_drop", 128'(keys_valid), 128'd0);
    wait_kv("zero");
    rk_idx = 4'd1;  step(); chk("zero_rk1",  rk_out, ZERO_RK1);
    rk_idx = 4'd10; step(); chk("zero_rk10", rk_out, ZERO_RK10);
    model_expand(128'h0);
    read_all("zero");

    // Second key held during expansion, accepted only once DONE
    key_a = {$urandom, $urandom, $urandom, $urandom};
    key_b = {$urandom, $urandom, $urandom, $urandom};
    old_rk10 = exp_rk[10];
    rk_idx = 4'd10;
    handshake(key_a);
    kif.key_in = key_b; kif.key_valid = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      chk($sformatf("hold_ready_%0d", k), 128'(kif.key_ready), 128'd0);
      chk($sformatf("hold_out_%0d", k), rk_out, old_rk10);
    end
    step();
    chk("hold_kv_rise", 128'(keys_valid), 128'd1);
    chk("hold_ready_done", 128'(kif.key_ready), 128'd1);
    step();
    kif.key_valid = 1'b0;
    model_expand(key_a);
    chk("hold_a_rk10", rk_out, exp_rk[10]);
    chk("hold_b_kv_drop", 128'(keys_valid), 128'd0);
    chk("hold_b_busy", 128'(busy), 128'd1);
    wait_kv("hold_b");
    model_expand(key_b);
    read_all("keyb");

    // Random seeds
    for (int n = 0; n < 3; n++) begin
      key_a = {$urandom, $urandom, $urandom, $urandom};
      handshake(key_a);
      wait_kv($sformatf("rnd%0d", n));
      model_expand(key_a);
      read_all($sformatf("rnd%0d", n));
    end

    // Clear wins over a simultaneous key offer in DONE
    key_clear = 1'b1;
    kif.key_in = FIPS_KEY; kif.key_valid = 1'b1;
    step();
    key_clear = 1'b0; kif.key_valid = 1'b0;
    chk("clr_kv",    128'(keys_valid), 128'd0);
    chk("clr_busy",  128'(busy), 128'd0);
    chk("clr_ready", 128'(kif.key_ready), 128'd1);
    chk("clr_rkout", rk_out, 128'h0);
    step();
    chk("clr_no_expand", 128'(busy), 128'd0);
    model_clear();
    read_all("clr");

    // Reset mid-expansion, then clean restart
    handshake(FIPS_KEY);
    for (int k = 0; k < 4; k++) step();
    chk("mid_busy", 128'(busy), 128'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_busy",  128'(busy), 128'd0);
    chk("mr_kv",    128'(keys_valid), 128'd0);
    chk("mr_ready", 128'(kif.key_ready), 128'd1);
    chk("mr_rkout", rk_out, 128'h0);
    step();
    rst_n = 1'b1;
    model_clear();
    read_all("mr");
    handshake(FIPS_KEY);
    wait_kv("mr_fips");
    rk_idx = 4'd10; step();
    chk("mr_fips_rk10", rk_out, FIPS_RK10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
